// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared FSM states, default sizes and butterfly address helper for the FFT sequencer
package fft_ctrl_pkg;
  localparam int DEF_LOG2N = 4;
  localparam int DEF_BFLY_LAT = 3;
  localparam int AW = 12;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] tw;
  } bfly_t;
  // Computed at the widest legal size; callers keep the low LOG2N bits.
  function automatic bfly_t bfly_addr(input logic [3:0] s, input logic [AW-1:0] k, input logic [3:0] log2n);
    logic [AW-1:0] span;
    logic [AW-1:0] pos;
    bfly_t r;
    span = AW'(1) << s;
    pos = k & (span - 1'b1);
    r.a = ((k >> s) << (s + 4'd1)) | pos;
    r.b = r.a + span;
    r.tw = pos << (log2n - 4'd1 - s);
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_dly.sv
// fft_addr_dly: fixed-depth shift-register delay line with async active-high clear
// Ports: clk, rst (async clear), d (WIDTH in), q (d delayed by DEPTH cycles)
module fft_addr_dly #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH*WIDTH-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= (sr << WIDTH) | (DEPTH*WIDTH)'(d);
  assign q = sr[DEPTH*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: stage/butterfly sequencer for an in-place radix-2 DIT FFT
// Ports: clk, rst (async, active-high), start, en (issue enable) in;
//   busy, done, stage, rd_en/rd_addr_a/rd_addr_b/tw_addr (issue side),
//   wr_en/wr_addr_a/wr_addr_b (issue side delayed by BFLY_LAT) out.
module fft_seq_ctrl import fft_ctrl_pkg::*; #(
  parameter int LOG2N = DEF_LOG2N,
  parameter int BFLY_LAT = DEF_BFLY_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N-1);
  localparam logic [LOG2N-2:0] K_LAST = '1;
  state_t state, state_n;
  logic [LOG2N-1:0] stage_n;
  logic [LOG2N-2:0] k, k_n;
  logic [3:0] cnt, cnt_n;
  logic ld;
  bfly_t nxt;
  logic unused_nxt;
  // Addresses are loaded for the butterfly about to be issued, so they are
  // already valid in the cycle rd_en rises and hold while nothing issues.
  always_comb begin
    state_n = state;
    stage_n = stage;
    k_n = k;
    cnt_n = cnt;
    ld = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        stage_n = '0;
        k_n = '0;
        ld = 1'b1;
      end
      RUN: if (en) begin
        if (k == K_LAST) begin
          state_n = DRAIN;
          cnt_n = 4'(BFLY_LAT);
        end else begin
          k_n = k + 1'b1;
          ld = 1'b1;
        end
      end
      DRAIN: begin
        cnt_n = cnt - 1'b1;
        if (cnt == 4'd1) begin
          if (stage == S_LAST) state_n = DONE;
          else begin
            state_n = RUN;
            stage_n = stage + 1'b1;
            k_n = '0;
            ld = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign nxt = bfly_addr(4'(stage_n), AW'(k_n), 4'(LOG2N));
  assign unused_nxt = &{1'b0, nxt};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      k <= '0;
      cnt <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      k <= k_n;
      cnt <= cnt_n;
      if (ld) begin
        rd_addr_a <= nxt.a[LOG2N-1:0];
        rd_addr_b <= nxt.b[LOG2N-1:0];
        tw_addr <= nxt.tw[LOG2N-2:0];
      end
    end
  assign rd_en = state == RUN && en;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  // Runs every cycle so pauses reach the write side as wr_en bubbles.
  fft_addr_dly #(.WIDTH(2*LOG2N+1), .DEPTH(BFLY_LAT)) u_dly (
    .clk(clk),
    .rst(rst),
    .d({rd_en, rd_addr_a, rd_addr_b}),
    .q({wr_en, wr_addr_a, wr_addr_b})
  );
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: scoreboard bench for fft_seq_ctrl (N=16, BFLY_LAT=3)
module tb_fft_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic en = 1'b1;
  logic busy, done, rd_en, wr_en;
  logic [3:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
  int cyc = 0;
  int vectors = 0;
  int errs = 0;
  logic chk_idle = 1'b0;
  typedef struct {int c; int s; int a; int b; int tw;} ev_t;
  typedef struct {int t0; int dn;} win_t;
  ev_t rdq[$];
  ev_t wrq[$];
  win_t wins[$];
  fft_seq_ctrl #(.LOG2N(4), .BFLY_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  // Expected issue schedule: per stage, every address with bit s clear in
  // ascending order is a top leg; pause cycles push issues later, and each
  // stage is followed by three drain cycles.
  task automatic plan(input int t0, input int plo, input int phi);
    int c = t0 + 1;
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 16; a++) begin
        if (((a >> s) & 1) == 0) begin
          while (c >= plo && c <= phi) c++;
          rdq.push_back('{c, s, a, a | (1 << s), (a & ((1 << s) - 1)) << (3 - s)});
          wrq.push_back('{c + 3, s, a, a | (1 << s), 0});
          c++;
        end
      end
      c += 3;
    end
    wins.push_back('{t0, c});
  endtask
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin : mon
    ev_t e;
    logic eb, ed;
    eb = 1'b0;
    ed = 1'b0;
    foreach (wins[i]) begin
      if (cyc > wins[i].t0 && cyc < wins[i].dn) eb = 1'b1;
      if (cyc == wins[i].dn) ed = 1'b1;
    end
    check("busy", 32'(busy), 32'(eb));
    check("done", 32'(done), 32'(ed));
    if (chk_idle)
      check("idle_zero", 32'({busy, done, rd_en, wr_en, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}), 0);
    if (rd_en) begin
      if (rdq.size() == 0) check("rd_extra", 32'(rd_en), 0);
      else begin
        e = rdq.pop_front();
        check("rd_cycle", cyc, e.c);
        check("rd_stage", 32'(stage), e.s);
        check("rd_a", 32'(rd_addr_a), e.a);
        check("rd_b", 32'(rd_addr_b), e.b);
        check("rd_tw", 32'(tw_addr), e.tw);
      end
    end else if (rdq.size() != 0 && rdq[0].c <= cyc) begin
      check("rd_missing", cyc, -1);
      void'(rdq.pop_front());
    end
    if (wr_en) begin
      if (wrq.size() == 0) check("wr_extra", 32'(wr_en), 0);
      else begin
        e = wrq.pop_front();
        check("wr_cycle", cyc, e.c);
        check("wr_a", 32'(wr_addr_a), e.a);
        check("wr_b", 32'(wr_addr_b), e.b);
      end
    end else if (wrq.size() != 0 && wrq[0].c <= cyc) begin
      check("wr_missing", cyc, -1);
      void'(wrq.pop_front());
    end
  end
  initial begin
    chk_idle = 1'b1;
    at(3);
    rst = 1'b0;
    at(53);
    chk_idle = 1'b0;
    at(60);
    plan(60, 0, -1);
    start = 1'b1;
    at(61);
    start = 1'b0;
    at(115);
    plan(120, 123, 124);
    at(120);
    start = 1'b1;
    at(121);
    start = 1'b0;
    at(123);
    en = 1'b0;
    at(125);
    en = 1'b1;
    at(175);
    plan(180, 0, -1);
    at(180);
    start = 1'b1;
    at(181);
    start = 1'b0;
    at(200);
    rst = 1'b1;
    chk_idle = 1'b1;
    rdq.delete();
    wrq.delete();
    wins.delete();
    at(202);
    rst = 1'b0;
    at(205);
    plan(205, 0, -1);
    start = 1'b1;
    at(206);
    chk_idle = 1'b0;
    start = 1'b0;
    at(265);
    plan(270, 0, -1);
    plan(316, 0, -1);
    at(270);
    start = 1'b1;
    at(317);
    start = 1'b0;
    at(380);
    check("rd_left", rdq.size(), 0);
    check("wr_left", wrq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
